// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern controller.
// BIST_EXHAUSTIVE_EN selects a binary-counter generator instead of the LFSR.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam int unsigned GEN_W     = 4;
  localparam int unsigned PNUM_W    = 5;
  localparam int unsigned NPAT_LFSR = 15;
  localparam int unsigned NPAT_EXH  = 16;

  localparam logic [GEN_W-1:0] LFSR_SEED = 4'b0001;
  // Feedback is q[3]^q[2]
  localparam logic [GEN_W-1:0] LFSR_TAPS = 4'b1100;
  localparam logic [7:0]       MISR_POLY = 8'h71;

`ifdef BIST_EXHAUSTIVE_EN
  localparam logic [GEN_W-1:0] GEN_SEED = 4'b0000;
  localparam int unsigned      NPAT     = NPAT_EXH;
`else
  localparam logic [GEN_W-1:0] GEN_SEED = LFSR_SEED;
  localparam int unsigned      NPAT     = NPAT_LFSR;
`endif

  function automatic logic [GEN_W-1:0] gen_next(input logic [GEN_W-1:0] q);
`ifdef BIST_EXHAUSTIVE_EN
    return q + GEN_W'(1);
`else
    return {q[GEN_W-2:0], ^(q & LFSR_TAPS)};
`endif
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Single-input signature register; clear has priority over capture.
module bist_misr
  import bist_pkg::*;
#(
  parameter int unsigned MISR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] fb;
  logic [MISR_W-1:0] sig_nxt;

  always_comb begin
    fb      = sig[MISR_W-1] ? MISR_W'(MISR_POLY) : '0;
    sig_nxt = {sig[MISR_W-2:0], 1'b0} ^ fb ^ MISR_W'(din);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (en) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/bist_pattern_ctrl.sv
// BIST controller: drives generator patterns, compacts responses into a MISR,
// and compares against GOLDEN. Optional build macro: BIST_EXHAUSTIVE_EN.
module bist_pattern_ctrl
  import bist_pkg::*;
#(
  parameter int unsigned       NINPUTS = 4,
  parameter int unsigned       MISR_W  = 8,
  parameter logic [MISR_W-1:0] GOLDEN  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [NINPUTS-1:0] pat_out,
  input  logic               resp_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [MISR_W-1:0]  signature,
  output logic [PNUM_W-1:0]  pattern_number
);

  state_t              state, state_nxt;
  logic [NINPUTS-1:0]  pat_nxt;
  logic [PNUM_W-1:0]   pnum_nxt;
  logic                busy_nxt;
  logic                done_nxt;
  logic                pass_nxt;
  logic                misr_clear;
  logic                misr_en;

  bist_misr #(
    .MISR_W (MISR_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (misr_clear),
    .en    (misr_en),
    .din   (resp_in),
    .sig   (signature)
  );

  // Next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    pat_nxt    = '0;
    pnum_nxt   = pattern_number;
    pass_nxt   = pass;
    misr_clear = 1'b0;
    misr_en    = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt  = ST_RUN;
          pat_nxt    = NINPUTS'(GEN_SEED);
          pnum_nxt   = '0;
          pass_nxt   = 1'b0;
          misr_clear = 1'b1;
        end
      end
      ST_RUN: begin
        misr_en  = 1'b1;
        pnum_nxt = pattern_number + PNUM_W'(1);
        if (pattern_number == PNUM_W'(NPAT - 1)) begin
          state_nxt = ST_CHECK;
        end else begin
          pat_nxt = NINPUTS'(gen_next(GEN_W'(pat_out)));
        end
      end
      ST_CHECK: begin
        pass_nxt  = (signature == GOLDEN);
        state_nxt = ST_DONE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_CHECK);
    done_nxt = (state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pat_out        <= '0;
      pattern_number <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      state          <= state_nxt;
      pat_out        <= pat_nxt;
      pattern_number <= pnum_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_bist_pattern_ctrl.sv
// Scoreboard bench for bist_pattern_ctrl: expected patterns and results are
// queued when a run is started and compared as the controller produces them.
module tb_bist_pattern_ctrl;

`ifdef BIST_EXHAUSTIVE_EN
  localparam int unsigned NP = 16;
`else
  localparam int unsigned NP = 15;
`endif

  function automatic logic [3:0] pat_at(input int i);
`ifdef BIST_EXHAUSTIVE_EN
    return 4'(i);
`else
    case (i)
      0:  return 4'd1;
      1:  return 4'd2;
      2:  return 4'd4;
      3:  return 4'd9;
      4:  return 4'd3;
      5:  return 4'd6;
      6:  return 4'd13;
      7:  return 4'd10;
      8:  return 4'd5;
      9:  return 4'd11;
      10: return 4'd7;
      11: return 4'd15;
      12: return 4'd14;
      13: return 4'd12;
      14: return 4'd8;
      default: return 4'd0;
    endcase
`endif
  endfunction

  // Circuit under test: Y = A&B | C^D with A = bit 3
  function automatic logic y_of(input logic [3:0] p);
    return (p[3] & p[2]) | (p[1] ^ p[0]);
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] m, input logic d);
    return {m[6:0], 1'b0} ^ (m[7] ? 8'h71 : 8'h00) ^ {7'b0, d};
  endfunction

  // mode 0: response tied 0, 1: fault-free circuit, 2: stuck-at-1
  function automatic logic [7:0] model_sig(input int m);
    logic [7:0] s;
    logic       d;
    s = 8'h00;
    for (int i = 0; i < int'(NP); i++) begin
      d = (m == 0) ? 1'b0 : (m == 1) ? y_of(pat_at(i)) : 1'b1;
      s = misr_step(s, d);
    end
    return s;
  endfunction

  localparam logic [7:0] GOLD = model_sig(1);

  typedef struct packed {
    logic [7:0] sig;
    logic       pass;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       resp_in;
  logic [3:0] pat_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] signature;
  logic [4:0] pattern_number;
  int         mode;

  int n_tests;
  int n_fail;

  logic [3:0] exp_pat_q[$];
  res_t       exp_res_q[$];

  bist_pattern_ctrl #(
    .NINPUTS (4),
    .MISR_W  (8),
    .GOLDEN  (GOLD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .pat_out        (pat_out),
    .resp_in        (resp_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .signature      (signature),
    .pattern_number (pattern_number)
  );

  assign resp_in = (mode == 0) ? 1'b0 : (mode == 1) ? y_of(pat_out) : 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_pat"},  32'(pat_out), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_done"}, 32'(done), 0);
    check_eq({tag, "_pass"}, 32'(pass), 0);
    check_eq({tag, "_sig"},  32'(signature), 0);
    check_eq({tag, "_pnum"}, 32'(pattern_number), 0);
  endtask

  task automatic push_run(input int m);
    logic [7:0] s;
    for (int i = 0; i < int'(NP); i++) exp_pat_q.push_back(pat_at(i));
    s = model_sig(m);
    exp_res_q.push_back('{sig: s, pass: (s == GOLD)});
  endtask

  // Called at a falling edge; hold keeps start high through the run,
  // abort_at >= 0 applies reset when that pattern index is observed.
  task automatic run_check(input int m, input bit hold, input int abort_at);
    int         wt;
    int         busy_n;
    int         idx;
    logic [3:0] ep;
    res_t       er;
    logic [7:0] sig_done;
    mode  = m;
    start = 1'b1;
    push_run(m);
    wt = 0;
    @(negedge clk);
    while (!busy && wt < 10) begin
      wt++;
      @(negedge clk);
    end
    if (!busy) begin
      check_eq("busy_rise_timeout", 32'(busy), 1);
      exp_pat_q.delete();
      exp_res_q.delete();
      start = 1'b0;
      return;
    end
    check_eq("run_sig_clear", 32'(signature), 0);
    check_eq("run_pnum_zero", 32'(pattern_number), 0);
    if (!hold) start = 1'b0;
    busy_n = 0;
    idx    = 0;
    while (busy && busy_n < 100) begin
      busy_n++;
      check_eq("done_low_busy", 32'(done), 0);
      if (exp_pat_q.size() > 0) begin
        ep = exp_pat_q.pop_front();
        check_eq($sformatf("pat%0d", idx), 32'(pat_out), 32'(ep));
        check_eq($sformatf("pnum%0d", idx), 32'(pattern_number), 32'(idx));
        if (abort_at >= 0 && idx == abort_at) begin
          rst_n = 1'b0;
          @(negedge clk);
          check_idle_zero("abort");
          rst_n = 1'b1;
          exp_pat_q.delete();
          exp_res_q.delete();
          @(negedge clk);
          check_eq("abort_no_done", 32'(done), 0);
          return;
        end
        idx++;
      end else begin
        check_eq("check_pat_zero", 32'(pat_out), 0);
      end
      @(negedge clk);
    end
    check_eq("busy_cycles", 32'(busy_n), 32'(NP + 1));
    check_eq("done_high", 32'(done), 1);
    check_eq("done_pat_zero", 32'(pat_out), 0);
    if (exp_res_q.size() > 0) begin
      er = exp_res_q.pop_front();
      check_eq("signature", 32'(signature), 32'(er.sig));
      check_eq("pass", 32'(pass), 32'(er.pass));
      if (!hold) begin
        sig_done = signature;
        repeat (3) @(negedge clk);
        check_eq("done_hold", 32'(done), 1);
        check_eq("done_busy_low", 32'(busy), 0);
        check_eq("sig_frozen", 32'(signature), 32'(er.sig));
        check_eq("pass_hold", 32'(pass), 32'(er.pass));
        check_eq("sig_stable", 32'(signature), 32'(sig_done));
      end
    end else begin
      check_eq("result_queue_empty", 0, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    mode    = 0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_zero("idle");

    // Response tied low: signature must stay zero
    run_check(0, 1'b0, -1);
    // Fault-free circuit matches the golden signature
    run_check(1, 1'b0, -1);
    // Stuck-at-1 response must not match
    run_check(2, 1'b0, -1);
    // start held through the run, then restart straight from DONE
    run_check(1, 1'b1, -1);
    run_check(0, 1'b0, -1);
    // Reset mid-run, then a full run
    run_check(1, 1'b0, 7);
    run_check(1, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bist_pattern_ctrl.md
BIST_PATTERN_CTRL -- requirements
Module: bist_pattern_ctrl

Interface
REQ-001 Parameter NINPUTS, default 4, number of DUT inputs driven (pattern width).
REQ-002 Parameter MISR_W, default 8, signature register width.
REQ-003 Parameter GOLDEN, default 8'h00, expected fault-free signature.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  level request to begin a self-test run.
REQ-007 pat_out  output  NINPUTS  stimulus applied to DUT inputs (A..D, bit 3 = A).
REQ-008 resp_in  input  1  DUT response (Y), combinational from pat_out.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high while the result is valid.
REQ-011 pass  output  1  signature matched GOLDEN; valid only when done=1.
REQ-012 signature  output  MISR_W  current MISR contents.
REQ-013 pattern_number  output  5  index of the pattern currently on pat_out.

Function
REQ-014 FSM states IDLE, RUN, CHECK, DONE, and only these.
REQ-015 IDLE: start=1 -> RUN next cycle; generator loaded with seed, MISR cleared to 0, pattern_number=0.
REQ-016 RUN: each cycle MISR absorbs resp_in for the pattern on pat_out; generator advances; pattern_number increments.
REQ-017 RUN -> CHECK on the cycle capturing pattern NPAT-1; exactly NPAT capture cycles per run.
REQ-018 CHECK: one cycle; pass <= (signature == GOLDEN); -> DONE.
REQ-019 DONE: done=1, pass held; start=1 -> RUN with reseed/clear as in IDLE; start=0 holds DONE.
REQ-020 start is ignored in RUN and CHECK.
REQ-021 busy=1 in RUN and CHECK; run length is NPAT+1 busy cycles.
REQ-022 pat_out = 0 in IDLE, CHECK and DONE; generator value in RUN.
REQ-023 Default generator: 4-bit Fibonacci LFSR, next = {q[2:0], q[3]^q[2]}, seed 4'b0001, NPAT=15; sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8.
REQ-024 MISR: next = {m[MISR_W-2:0], 1'b0} XOR (m[MISR_W-1] ? 8'h71 : 0) XOR {0..., resp_in}.
REQ-025 signature is frozen in CHECK and DONE, and is cleared only at run start or reset.

Reset
REQ-026 rst_n=0 at a clock edge forces IDLE, pat_out=0, busy=0, done=0, pass=0, signature=0, pattern_number=0.
REQ-027 Reset mid-run aborts without producing done; the next start performs a full run.

Configuration
REQ-028 Macro BIST_EXHAUSTIVE_EN defined: generator is a 4-bit binary up-counter, seed 0, NPAT=16 (sequence 0..15, includes all-zero).
REQ-029 BIST_EXHAUSTIVE_EN undefined: LFSR per REQ-023, NPAT=15; all other behaviour is identical.

Structure
REQ-030 Package bist_pkg holds: state enum, LFSR seed/taps, MISR polynomial 8'h71, NPAT constants for both configurations.
REQ-031 Sub-module bist_misr (clk, rst_n, clear, en, din, sig) implements REQ-024; the controller instantiates it once.

Verification
REQ-032 Reset, start pulse, resp_in tied 0, GOLDEN=8'h00 -> pat_out follows REQ-023 sequence; busy high 16 cycles; signature=8'h00; done=1, pass=1.
REQ-033 Fault-free DUT (Y = A&B | C^D) with GOLDEN from reference model -> pass=1; same bench with Y stuck-at-1 -> done=1, pass=0.
REQ-034 start held high through RUN -> no restart during RUN; in DONE, start=1 -> new run, pattern_number=0, signature cleared.
REQ-035 rst_n=0 at pattern_number=7 -> next cycle IDLE, all outputs 0; a following start completes a full 15-pattern run.
REQ-036 Compile with BIST_EXHAUSTIVE_EN -> pat_out 0..15 in order, 17 busy cycles, resp_in=0 gives signature 8'h00.
